// File: rtl/regfile_mp.sv
// Multi-port register file with write forwarding and a busy scoreboard.
// Reads are combinational; writes, issues and the scoreboard update on clk.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = ($clog2(NREG) < 1) ? 1 : $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*XLEN-1:0]  rd,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*XLEN-1:0]  wd,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic [NREG-1:0]      busy_vec
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic [AW-1:0]   ra_a;
    logic [XLEN-1:0] rd_v;
    logic            rb_v;

    // Next state: later write ports override earlier ones, issue beats clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 0; r < NREG; r++) begin
            if (!(ZR && r == 0)) begin
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && wa[j*AW +: AW] == AW'(r)) begin
                        regs_d[r] = wd[j*XLEN +: XLEN];
                        busy_d[r] = 1'b0;
                    end
                end
                if (iss_en && iss_addr == AW'(r)) begin
                    busy_d[r] = 1'b1;
                end
            end
        end
    end

    // Storage and scoreboard flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Read ports: decoded lookup, optional forwarding, forced zero in reset.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        ra_a    = '0;
        rd_v    = '0;
        rb_v    = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra_a = ra[i*AW +: AW];
            rd_v = '0;
            rb_v = 1'b0;
            for (int r = 0; r < NREG; r++) begin
                if (!(ZR && r == 0) && ra_a == AW'(r)) begin
                    rd_v = regs_q[r];
                    rb_v = busy_q[r];
                    if (BP) begin
                        for (int j = 0; j < NWR; j++) begin
                            if (we[j] && wa[j*AW +: AW] == ra_a) begin
                                rd_v = wd[j*XLEN +: XLEN];
                                rb_v = 1'b0;
                            end
                        end
                    end
                end
            end
            if (!rst_n) begin
                rd_v = '0;
                rb_v = 1'b0;
            end
            rd[i*XLEN +: XLEN] = rd_v;
            rd_busy[i]         = rb_v;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed checks plus random traffic
// compared against a behavioural register/scoreboard model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [31:0] busy_vec;

    logic [14:0] s_ra;
    logic [95:0] s_rd;
    logic [2:0]  s_rb;
    logic [0:0]  s_we;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic        s_iss;
    logic [4:0]  s_ia;
    logic [19:0] s_busy;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    logic [31:0] mreg [32];
    logic [31:0] mbusy;

    regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n),
        .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_vec(busy_vec)
    );

    regfile_mp #(.NREG(20), .NRD(3), .NWR(1)) u_sw (
        .clk(clk), .rst_n(rst_n),
        .ra(s_ra), .rd(s_rd), .rd_busy(s_rb),
        .we(s_we), .wa(s_wa), .wd(s_wd),
        .iss_en(s_iss), .iss_addr(s_ia),
        .busy_vec(s_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int i);
        logic [4:0]  a;
        logic [31:0] v;
        a = ra[i*5 +: 5];
        if (!rst_n || a == 5'd0) return 32'd0;
        v = mreg[a];
        for (int j = 0; j < 2; j++)
            if (we[j] && wa[j*5 +: 5] == a) v = wd[j*32 +: 32];
        return v;
    endfunction

    function automatic logic exp_rb(input int i);
        logic [4:0] a;
        a = ra[i*5 +: 5];
        if (!rst_n || a == 5'd0) return 1'b0;
        for (int j = 0; j < 2; j++)
            if (we[j] && wa[j*5 +: 5] == a) return 1'b0;
        return mbusy[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) mreg[k] = 32'd0;
            mbusy = 32'd0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j*5 +: 5] != 5'd0) begin
                    mreg[wa[j*5 +: 5]]  = wd[j*32 +: 32];
                    mbusy[wa[j*5 +: 5]] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 5'd0) mbusy[iss_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("model_rd", rd[i*32 +: 32], exp_rd(i));
                chk("model_rd_busy", {31'd0, rd_busy[i]}, {31'd0, exp_rb(i)});
            end
            chk("model_busy_vec", busy_vec, mbusy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] w, input logic [4:0] a1,
                       input logic [31:0] d1, input logic [4:0] a0,
                       input logic [31:0] d0, input logic [4:0] r1,
                       input logic [4:0] r0);
        we = w;
        wa = {a1, a0};
        wd = {d1, d0};
        ra = {r1, r0};
    endtask

    initial begin
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
        iss_en = 1'b0; iss_addr = 5'd0;
        s_ra = '0; s_we = '0; s_wa = '0; s_wd = '0; s_iss = 1'b0; s_ia = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_rd", rd[31:0], 32'd0);
        chk("reset_busy_vec", busy_vec, 32'd0);
        cmp_on = 1'b1;
        #10 rst_n = 1'b1;
        tick();

        // x10 and x0 write, bypass then stored
        drv(2'b11, 5'd0, 32'hFFFFFFFF, 5'd10, 32'hABCDEFAB, 5'd0, 5'd10);
        #1;
        chk("bypass_x10", rd[31:0], 32'hABCDEFAB);
        chk("bypass_x0", rd[63:32], 32'd0);
        tick();
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd10);
        #1;
        chk("read_x10", rd[31:0], 32'hABCDEFAB);
        chk("read_x0", rd[63:32], 32'd0);
        ra[9:5] = 5'd20;
        #1 chk("read_x20", rd[63:32], 32'd0);

        // collision on x5
        tick();
        drv(2'b11, 5'd5, 32'h22222222, 5'd5, 32'h11111111, 5'd0, 5'd5);
        #1 chk("collide_bypass", rd[31:0], 32'h22222222);
        tick();
        we = 2'b00;
        #1 chk("collide_stored", rd[31:0], 32'h22222222);

        // scoreboard on x7
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        iss_en = 1'b0;
        ra = {5'd0, 5'd7};
        #1;
        chk("busy7_set", {31'd0, busy_vec[7]}, 32'd1);
        chk("rd_busy7", {30'd0, rd_busy}, 32'd1);
        drv(2'b01, 5'd0, 32'd0, 5'd7, 32'h33333333, 5'd0, 5'd7);
        #1;
        chk("rd_busy7_fwd", {30'd0, rd_busy}, 32'd0);
        chk("rd7_fwd", rd[31:0], 32'h33333333);
        tick();
        we = 2'b00;
        #1 chk("busy7_clear", {31'd0, busy_vec[7]}, 32'd0);
        iss_en = 1'b1;
        drv(2'b01, 5'd0, 32'd0, 5'd7, 32'h44444444, 5'd0, 5'd7);
        tick();
        iss_en = 1'b0; we = 2'b00;
        #1 chk("busy7_set_wins", {31'd0, busy_vec[7]}, 32'd1);

        // async reset mid-cycle after writing x6
        drv(2'b01, 5'd0, 32'd0, 5'd6, 32'hDEADBEEF, 5'd0, 5'd6);
        tick();
        we = 2'b00;
        #1 chk("read_x6", rd[31:0], 32'hDEADBEEF);
        rst_n = 1'b0;
        drv(2'b01, 5'd0, 32'd0, 5'd6, 32'h12345678, 5'd0, 5'd6);
        iss_en = 1'b1; iss_addr = 5'd9;
        #1;
        chk("rst_rd_x6", rd[31:0], 32'd0);
        chk("rst_busy_vec", busy_vec, 32'd0);
        chk("rst_rd_busy", {30'd0, rd_busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        we = 2'b00; iss_en = 1'b0;
        tick();
        chk("post_rst_x6", rd[31:0], 32'd0);
        chk("post_rst_busy", busy_vec, 32'd0);

        // sweep instance: NREG=20, NRD=3, NWR=1
        s_we = 1'b1; s_wa = 5'd25; s_wd = 32'hAAAA5555;
        s_ra = {5'd25, 5'd25, 5'd25};
        #1 chk("sw_oob_bypass", s_rd[31:0], 32'd0);
        tick();
        s_wa = 5'd19; s_wd = 32'h19191919;
        #1 chk("sw_oob_stored", s_rd[31:0], 32'd0);
        tick();
        s_we = 1'b0;
        s_ra = {5'd19, 5'd19, 5'd19};
        #1;
        for (int i = 0; i < 3; i++)
            chk("sw_x19_port", s_rd[i*32 +: 32], 32'h19191919);
        s_ra = {5'd19, 5'd25, 5'd19};
        #1;
        chk("sw_mix_p0", s_rd[31:0], 32'h19191919);
        chk("sw_mix_p1", s_rd[63:32], 32'd0);
        chk("sw_mix_p2", s_rd[95:64], 32'h19191919);
        s_iss = 1'b1; s_ia = 5'd25;
        tick();
        s_ia = 5'd19;
        tick();
        s_iss = 1'b0;
        #1;
        chk("sw_busy_vec", {12'd0, s_busy}, 32'h00080000);
        chk("sw_rd_busy", {29'd0, s_rb}, 32'd5);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] a0, a1;
            a0 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            we = 2'($urandom);
            wa = {a1, a0};
            wd = {$urandom, $urandom};
            ra[4:0] = $urandom_range(0, 1) ? a0 : 5'($urandom_range(0, 7));
            ra[9:5] = $urandom_range(0, 1) ? a1 : 5'($urandom);
            iss_en = ($urandom_range(0, 3) == 0);
            iss_addr = $urandom_range(0, 1) ? a0 : 5'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
